sync_fifo_flags: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count output, and sticky overflow/underflow error flags.
- Adds a selectable read mode: first-word-fall-through or registered one-cycle-latency read.
- Used as the standard buffer between streaming blocks in the single-clock fabric design.

---
 rtl/sync_fifo_flags.sv | 114 +++++++++++
 tb/tb_sync_fifo_flags.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode
// (first-word-fall-through or registered one-cycle-latency read).
//
// Handshake: wr_en and rd_en are requests sampled at the rising edge. A write
// is taken only when ~full and a read only when ~empty; a refused request has
// no effect except setting the matching sticky error flag. dout_valid marks
// the cycles in which dout carries a real word.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered count; full/empty are told
    // apart only by count, so the pointers may wrap freely.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is always presented; rd_en only advances past it.
            assign dout       = mem[rd_ptr];
            assign dout_valid = ~empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_r;
            logic                  dout_valid_r;

            // Popped word is captured on the read edge and held until the next pop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_r       <= '0;
                    dout_valid_r <= 1'b0;
                end else begin
                    dout_valid_r <= rd_acc;
                    if (rd_acc) begin
                        dout_r <= mem[rd_ptr];
                    end
                end
            end

            assign dout       = dout_r;
            assign dout_valid = dout_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one instance in first-word-fall-through
// mode (defaults, DEPTH=16, AF=14, AE=2) and one in registered-read mode.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;

    logic       a_wr_en;
    logic [7:0] a_din;
    logic       a_rd_en;
    logic [7:0] a_dout;
    logic       a_dout_valid;
    logic       a_full;
    logic       a_empty;
    logic       a_almost_full;
    logic       a_almost_empty;
    logic [4:0] a_count;
    logic       a_overflow;
    logic       a_underflow;

    logic       b_wr_en;
    logic [7:0] b_din;
    logic       b_rd_en;
    logic [7:0] b_dout;
    logic       b_dout_valid;
    logic       b_full;
    logic       b_empty;
    logic       b_almost_full;
    logic       b_almost_empty;
    logic [4:0] b_count;
    logic       b_overflow;
    logic       b_underflow;

    int n_checks;
    int n_errors;

    logic [7:0] exp_q[$];
    logic [7:0] head;

    sync_fifo_flags #(.FWFT(1'b1)) u_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (a_wr_en),
        .din          (a_din),
        .rd_en        (a_rd_en),
        .dout         (a_dout),
        .dout_valid   (a_dout_valid),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_almost_full),
        .almost_empty (a_almost_empty),
        .count        (a_count),
        .overflow     (a_overflow),
        .underflow    (a_underflow)
    );

    sync_fifo_flags #(.FWFT(1'b0)) u_reg (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (b_wr_en),
        .din          (b_din),
        .rd_en        (b_rd_en),
        .dout         (b_dout),
        .dout_valid   (b_dout_valid),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_almost_full),
        .almost_empty (b_almost_empty),
        .count        (b_count),
        .overflow     (b_overflow),
        .underflow    (b_underflow)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic wr, input logic rd, input logic [7:0] d);
        a_wr_en = wr;
        a_rd_en = rd;
        a_din   = d;
        step();
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
    endtask

    task automatic drive_b(input logic wr, input logic rd, input logic [7:0] d);
        b_wr_en = wr;
        b_rd_en = rd;
        b_din   = d;
        step();
        b_wr_en = 1'b0;
        b_rd_en = 1'b0;
    endtask

    // Compare the FWFT head against the scoreboard and retire it.
    task automatic check_head(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            head = exp_q.pop_front();
            check(tag, {24'd0, a_dout}, {24'd0, head});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_din = 8'h00;
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = 8'h00;

        // Reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_count",     {27'd0, a_count}, 32'd0);
        check("rst_empty",     {31'd0, a_empty}, 32'd1);
        check("rst_ae",        {31'd0, a_almost_empty}, 32'd1);
        check("rst_full",      {31'd0, a_full}, 32'd0);
        check("rst_af",        {31'd0, a_almost_full}, 32'd0);
        check("rst_ovf",       {31'd0, a_overflow}, 32'd0);
        check("rst_udf",       {31'd0, a_underflow}, 32'd0);
        check("rst_dv_fwft",   {31'd0, a_dout_valid}, 32'd0);
        check("rst_dv_reg",    {31'd0, b_dout_valid}, 32'd0);
        check("rst_dout_reg",  {24'd0, b_dout}, 32'd0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b1, 1'b0, 8'(i));
            exp_q.push_back(8'(i));
            check("fill_count", {27'd0, a_count}, 32'(i + 1));
            check("fill_af",    {31'd0, a_almost_full}, {31'd0, (i + 1) >= 14});
            check("fill_full",  {31'd0, a_full}, {31'd0, (i + 1) == 16});
            if (i == 0) begin
                check("fwft_first_dout", {24'd0, a_dout}, 32'h00);
                check("fwft_first_dv",   {31'd0, a_dout_valid}, 32'd1);
            end
        end

        // Overflow attempt
        drive_a(1'b1, 1'b0, 8'hAA);
        check("ovf_set",   {31'd0, a_overflow}, 32'd1);
        check("ovf_count", {27'd0, a_count}, 32'd16);
        step();
        check("ovf_sticky", {31'd0, a_overflow}, 32'd1);

        // Drain 17 reads; last one underflows
        for (int k = 0; k < 17; k++) begin
            if (k < 16) begin
                check("drain_dv", {31'd0, a_dout_valid}, 32'd1);
                check_head("drain_dout");
            end
            drive_a(1'b0, 1'b1, 8'h00);
            check("drain_count", {27'd0, a_count}, (k < 16) ? 32'(15 - k) : 32'd0);
            check("drain_ae",    {31'd0, a_almost_empty}, {31'd0, k >= 13});
            check("drain_empty", {31'd0, a_empty}, {31'd0, k >= 15});
            check("drain_udf",   {31'd0, a_underflow}, {31'd0, k == 16});
        end

        // Simultaneous rd/wr when empty: read refused
        drive_a(1'b1, 1'b1, 8'h50);
        exp_q.push_back(8'h50);
        check("emp_rw_count", {27'd0, a_count}, 32'd1);
        check("emp_rw_dout",  {24'd0, a_dout}, 32'h50);

        // Simultaneous rd/wr at count 1: old head out, new word becomes head
        check_head("c1_pop");
        drive_a(1'b1, 1'b1, 8'h51);
        exp_q.push_back(8'h51);
        check("c1_count", {27'd0, a_count}, 32'd1);
        check("c1_head",  {24'd0, a_dout}, 32'h51);

        drive_a(1'b1, 1'b0, 8'h52);
        exp_q.push_back(8'h52);
        drive_a(1'b1, 1'b0, 8'h53);
        exp_q.push_back(8'h53);
        check("steady_start", {27'd0, a_count}, 32'd3);

        // Steady state at count 3 across several pointer wraps
        for (int i = 0; i < 40; i++) begin
            check_head("steady_dout");
            drive_a(1'b1, 1'b1, 8'(8'h54 + i));
            exp_q.push_back(8'(8'h54 + i));
            check("steady_count", {27'd0, a_count}, 32'd3);
        end

        // Top up to full, then simultaneous rd/wr: write refused
        for (int i = 0; i < 13; i++) begin
            drive_a(1'b1, 1'b0, 8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
        end
        check("full_again", {31'd0, a_full}, 32'd1);
        check_head("full_rw_pop");
        drive_a(1'b1, 1'b1, 8'hBB);
        check("full_rw_count", {27'd0, a_count}, 32'd15);
        check("full_rw_full",  {31'd0, a_full}, 32'd0);

        // Drain and confirm 0xBB never entered the FIFO
        for (int i = 0; i < 15; i++) begin
            check_head("full_drain");
            drive_a(1'b0, 1'b1, 8'h00);
        end
        check("full_drain_empty", {31'd0, a_empty}, 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset with count 7 and overflow still set
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b1, 1'b0, 8'(8'h60 + i));
        end
        check("pre_rst_count", {27'd0, a_count}, 32'd7);
        check("pre_rst_ovf",   {31'd0, a_overflow}, 32'd1);
        rst = 1'b1;
        drive_a(1'b1, 1'b1, 8'hEE);
        rst = 1'b0;
        check("mid_rst_count", {27'd0, a_count}, 32'd0);
        check("mid_rst_empty", {31'd0, a_empty}, 32'd1);
        check("mid_rst_ovf",   {31'd0, a_overflow}, 32'd0);
        check("mid_rst_udf",   {31'd0, a_underflow}, 32'd0);
        check("mid_rst_dv",    {31'd0, a_dout_valid}, 32'd0);
        step();
        check("post_rst_idle", {27'd0, a_count}, 32'd0);
        drive_a(1'b1, 1'b0, 8'h77);
        check("post_rst_wr_count", {27'd0, a_count}, 32'd1);
        check("post_rst_wr_dout",  {24'd0, a_dout}, 32'h77);

        // Registered-read instance
        drive_b(1'b1, 1'b0, 8'h11);
        check("reg_wr_dv", {31'd0, b_dout_valid}, 32'd0);
        drive_b(1'b1, 1'b0, 8'h22);
        check("reg_count2", {27'd0, b_count}, 32'd2);
        check("reg_wr_dv2", {31'd0, b_dout_valid}, 32'd0);
        b_rd_en = 1'b1;
        step();
        check("reg_rd1_dv",   {31'd0, b_dout_valid}, 32'd1);
        check("reg_rd1_dout", {24'd0, b_dout}, 32'h11);
        step();
        check("reg_rd2_dv",   {31'd0, b_dout_valid}, 32'd1);
        check("reg_rd2_dout", {24'd0, b_dout}, 32'h22);
        b_rd_en = 1'b0;
        step();
        check("reg_hold_dv",    {31'd0, b_dout_valid}, 32'd0);
        check("reg_hold_dout",  {24'd0, b_dout}, 32'h22);
        check("reg_hold_empty", {31'd0, b_empty}, 32'd1);
        drive_b(1'b0, 1'b1, 8'h00);
        check("reg_udf",      {31'd0, b_underflow}, 32'd1);
        check("reg_udf_dv",   {31'd0, b_dout_valid}, 32'd0);
        check("reg_udf_dout", {24'd0, b_dout}, 32'h22);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
